// File: rtl/sad_absdiff_accumulator.sv
// Purpose: accumulates |pix_a - pix_b| over N_SAMPLES accepted pairs into one block SAD.
// Latency: sad_valid and final sad two edges after the last accepted sample (diff stage + add stage).
// Backpressure: in_ready is high only while accumulating; samples outside that window are dropped.
//
// Ports:
//   clk, rst (async, active-low)    clock and reset
//   start                           begin a new block; taken only when idle or done
//   in_valid, pix_a, pix_b          operand pair, consumed when in_valid & in_ready
//   in_ready                        accepting samples (state-decoded)
//   sad, sad_valid                  accumulated SAD, final while sad_valid is high
//   busy                            block in progress (accumulating or draining)
module sad_absdiff_accumulator #(
    parameter int DATA_W    = 8,
    parameter int N_SAMPLES = 16,
    parameter int ACC_W     = DATA_W + $clog2(N_SAMPLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pix_a,
    input  logic [DATA_W-1:0] pix_b,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sad,
    output logic              sad_valid,
    output logic              busy
);

    // One extra bit so the counter can hold N_SAMPLES itself without wrapping.
    localparam int CNT_W = $clog2(N_SAMPLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [DATA_W-1:0]  diff;
    logic               diff_valid;
    logic [ACC_W-1:0]   acc;

    logic               accept;
    logic               restart;
    logic               last_accept;

    assign in_ready    = (state == ACCUM);
    assign accept      = in_valid & in_ready;
    assign restart     = start & ((state == IDLE) | (state == DONE));
    assign last_accept = accept & (count == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last_accept) state_nxt = DRAIN;
            // One cycle lets the final staged diff reach the accumulator.
            DRAIN:   state_nxt = DONE;
            DONE:    if (start) state_nxt = ACCUM;
            default: state_nxt = IDLE;
        endcase
    end

    // Two-stage datapath: stage 1 registers the absolute difference, stage 2
    // adds it. Stage 2 ignores state so the last difference lands in DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            diff       <= '0;
            diff_valid <= 1'b0;
            acc        <= '0;
        end else if (restart) begin
            count      <= '0;
            diff_valid <= 1'b0;
            acc        <= '0;
        end else begin
            if (accept) begin
                diff       <= (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);
                diff_valid <= 1'b1;
                count      <= count + 1'b1;
            end else begin
                diff_valid <= 1'b0;
            end
            if (diff_valid) begin
                acc <= acc + {{(ACC_W - DATA_W){1'b0}}, diff};
            end
        end
    end

    assign sad       = acc;
    assign sad_valid = (state == DONE);
    assign busy      = (state == ACCUM) | (state == DRAIN);

endmodule

// File: tb/tb_sad_absdiff_accumulator.sv
module tb_sad_absdiff_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  pix_a;
    logic [7:0]  pix_b;
    logic        in_ready;
    logic [11:0] sad;
    logic        sad_valid;
    logic        busy;

    int tests;
    int fails;

    // Operand pairs for the next block, indexed by accepted-sample number.
    logic [7:0] sa [16];
    logic [7:0] sb [16];

    sad_absdiff_accumulator #(
        .DATA_W    (8),
        .N_SAMPLES (16),
        .ACC_W     (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .pix_a     (pix_a),
        .pix_b     (pix_b),
        .in_ready  (in_ready),
        .sad       (sad),
        .sad_valid (sad_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int ref_block_sum();
        int s = 0;
        for (int k = 0; k < 16; k++) s += absd(int'(sa[k]), int'(sb[k]));
        return s;
    endfunction

    // Inputs change at the falling edge; outputs are read at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_const(input int a, input int b);
        for (int k = 0; k < 16; k++) begin
            sa[k] = 8'(a);
            sb[k] = 8'(b);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++) begin
            sa[k] = 8'($urandom_range(0, 255));
            sb[k] = 8'($urandom_range(0, 255));
        end
    endtask

    // gap_mode: 0 = in_valid held high, 1 = toggling 1,0,1,0..., 2 = random gaps.
    // exp_sad / exp_cycles < 0 means no fixed constant to compare against.
    task automatic run_block(input int gap_mode, input bit mid_start,
                             input int exp_sad, input int exp_cycles);
        int ref_sum;
        int i;
        int cyc;
        int zeros;
        bit v;
        ref_sum = ref_block_sum();
        i = 0;
        cyc = 0;
        zeros = 0;

        start = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || sad_valid !== 1'b0 || sad !== 12'd0) begin
            fails++;
            $display("FAIL block_start: in_ready=%0b busy=%0b sad_valid=%0b sad=%0d, required 1 1 0 0",
                     in_ready, busy, sad_valid, sad);
        end

        while (i < 16 && cyc < 200) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = (zeros >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            endcase
            zeros = v ? 0 : zeros + 1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL accum_ready: cycle %0d in_ready=%0b, required 1", cyc, in_ready);
            end
            in_valid = v;
            pix_a = v ? sa[i] : 8'($urandom_range(0, 255));
            pix_b = v ? sb[i] : 8'($urandom_range(0, 255));
            start = mid_start && (cyc == 5);
            step();
            start = 1'b0;
            cyc++;
            if (v) i++;
        end
        if (cyc >= 200) begin
            tests++;
            fails++;
            $display("FAIL accum_timeout: %0d samples sent in %0d cycles", i, cyc);
        end
        if (exp_cycles >= 0) begin
            tests++;
            if (cyc != exp_cycles) begin
                fails++;
                $display("FAIL accum_cycles: %0d, required %0d", cyc, exp_cycles);
            end
        end

        // Drain cycle: a sample offered here must be ignored.
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || sad_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain: in_ready=%0b busy=%0b sad_valid=%0b, required 0 1 0",
                     in_ready, busy, sad_valid);
        end
        in_valid = 1'b1;
        pix_a = 8'($urandom_range(0, 255));
        pix_b = 8'($urandom_range(0, 255));
        step();

        tests++;
        if (sad_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || sad !== 12'(ref_sum)) begin
            fails++;
            $display("FAIL done: sad_valid=%0b busy=%0b in_ready=%0b sad=%0d, required 1 0 0 %0d",
                     sad_valid, busy, in_ready, sad, ref_sum);
        end
        if (exp_sad >= 0) begin
            tests++;
            if (sad !== 12'(exp_sad)) begin
                fails++;
                $display("FAIL sad_value: %0d, required %0d", sad, exp_sad);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        start = 1'b0;
        in_valid = 1'b0;
        pix_a = '0;
        pix_b = '0;
        rst = 1'b0;
        @(negedge clk);
        step();
        tests++;
        if (in_ready !== 1'b0 || sad !== 12'd0 || sad_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: in_ready=%0b sad=%0d sad_valid=%0b busy=%0b, required 0 0 0 0",
                     in_ready, sad, sad_valid, busy);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        fill_const(200, 50);
        run_block(0, 1'b0, 2400, 16);
    endtask

    task automatic test_ordering();
        fill_const(10, 250);
        run_block(0, 1'b0, 3840, 16);
        for (int k = 0; k < 16; k++) begin
            sa[k] = (k < 8) ? 8'd5 : 8'd3;
            sb[k] = (k < 8) ? 8'd3 : 8'd5;
        end
        run_block(0, 1'b0, 32, 16);
    endtask

    task automatic test_gaps();
        fill_const(255, 0);
        run_block(1, 1'b0, 4080, 31);
    endtask

    task automatic test_protocol();
        int exp;
        apply_reset();
        // Idle: valid data offered without start must not be consumed.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pix_a = 8'($urandom_range(0, 255));
            pix_b = 8'($urandom_range(0, 255));
            step();
            tests++;
            if (in_ready !== 1'b0 || busy !== 1'b0 || sad_valid !== 1'b0) begin
                fails++;
                $display("FAIL idle_ignore: in_ready=%0b busy=%0b sad_valid=%0b, required 0 0 0",
                         in_ready, busy, sad_valid);
            end
        end
        in_valid = 1'b0;
        fill_random();
        exp = ref_block_sum();
        run_block(2, 1'b1, -1, -1);
        // Done: result holds while valid data is offered and start stays low.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pix_a = 8'($urandom_range(0, 255));
            pix_b = 8'($urandom_range(0, 255));
            step();
            tests++;
            if (sad_valid !== 1'b1 || in_ready !== 1'b0 || sad !== 12'(exp)) begin
                fails++;
                $display("FAIL done_hold: sad_valid=%0b in_ready=%0b sad=%0d, required 1 0 %0d",
                         sad_valid, in_ready, sad, exp);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill_const(1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        pix_a = 8'd1;
        pix_b = 8'd0;
        for (int k = 0; k < 7; k++) step();
        in_valid = 1'b0;
        tests++;
        if (sad !== 12'd6 || busy !== 1'b1) begin
            fails++;
            $display("FAIL partial_block: sad=%0d busy=%0b, required 6 1", sad, busy);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0 || sad !== 12'd0 || sad_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: in_ready=%0b sad=%0d sad_valid=%0b busy=%0b, required 0 0 0 0",
                     in_ready, sad, sad_valid, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || sad_valid !== 1'b0 || sad !== 12'd0) begin
            fails++;
            $display("FAIL post_reset_idle: in_ready=%0b busy=%0b sad_valid=%0b sad=%0d, required 0 0 0 0",
                     in_ready, busy, sad_valid, sad);
        end
        run_block(0, 1'b0, 16, 16);
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_block(2, 1'b0, -1, -1);
        // Restart in the first done cycle; run_block checks the drop of sad_valid and sad.
        fill_const(100, 99);
        run_block(0, 1'b0, 16, 16);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_block(r % 3, (r % 2) == 1, -1, -1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_ordering();
        test_gaps();
        test_protocol();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sad_absdiff_accumulator.md
# sad_absdiff_accumulator

Downstream SAD stage for the neuron sum-of-absolute-differences datapath. It takes a stream of 8-bit operand pairs, forms |a − b| per pair, and accumulates exactly N_SAMPLES differences into one block SAD. A valid/ready handshake paces input; the result is held with `sad_valid` until the next block starts. It uses the same `start`-driven control style as the 8-bit adder stage it sits beside.

## Interface
- `DATA_W`, 8, operand width in bits.
- `N_SAMPLES`, 16, differences per block; must be a power of two, at least 2.
- `ACC_W`, DATA_W + log2(N_SAMPLES) = 12, accumulator/result width; the sum cannot overflow.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately when low.
- `start`  in  1  one-cycle request to begin a new block; honoured only in IDLE or DONE.
- `in_valid`  in  1  `pix_a` and `pix_b` carry a sample this cycle.
- `pix_a`  in  DATA_W  unsigned operand a.
- `pix_b`  in  DATA_W  unsigned operand b.
- `in_ready`  out  1  block accepts a sample this cycle; combinational from state only.
- `sad`  out  ACC_W  accumulated SAD; registered.
- `sad_valid`  out  1  `sad` is final for the current block; registered via state.
- `busy`  out  1  high in ACCUM or DRAIN.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE. Reset state is IDLE.
- IDLE, or DONE with `start`=1: go to ACCUM. Clear the accumulator, the sample counter and the diff-valid flag. `sad_valid` drops.
- ACCUM:
  - `in_ready`=1.
  - Accept = `in_valid` & `in_ready`.
  - On accept, stage 1 registers diff = (a ≥ b) ? a−b : b−a (unsigned, DATA_W bits) and sets diff_valid.
  - Without an accept, diff_valid clears.
  - The counter increments on each accept. After the accept that makes count = N_SAMPLES, go to DRAIN.
- Stage 2 runs every cycle: if diff_valid, acc ← acc + zero-extended diff. It is independent of state, so the last diff lands during DRAIN.
- DRAIN: `in_ready`=0. Go to DONE unconditionally after one cycle, when the last addition completes.
- DONE:
  - `sad_valid`=1 and `sad` = acc, held stable.
  - `start` restarts the block (back to ACCUM); otherwise remain in DONE.
- `start` in ACCUM or DRAIN is ignored, with no effect on count or acc.
- `in_valid` outside ACCUM is ignored; no sample is consumed.
- Counter width is log2(N_SAMPLES)+1. It never wraps within a block.
- Reset mid-block (`rst` low in any state):
  - State → IDLE.
  - acc, counter, diff register and diff_valid → 0.
  - All outputs drop to reset values asynchronously.
  - The partial block is discarded.

## Timing
- Reset values: `in_ready`=0, `sad`=0, `sad_valid`=0, `busy`=0.
- Edge E0 samples `start`=1: ACCUM is visible after E0, and `in_ready`=1 from that cycle.
- Throughput: one sample per cycle while `in_valid` is held high. A full block takes N_SAMPLES cycles with no bubbles. Gaps in `in_valid` only stretch ACCUM.
- Latency: the Nth sample is accepted at edge E. DRAIN is visible after E, and `sad_valid`=1 with the final `sad` after E+1. `in_ready` is 0 from the cycle after E.
- Minimum block period: start cycle + N_SAMPLES accept cycles + 1 DRAIN cycle. `start` asserted in the first DONE cycle gives back-to-back blocks.
- When a restart is taken, `sad_valid` falls on the same edge that enters ACCUM. `sad` reads 0 from then until the next accumulation.

## Test plan
- Reset then start; 16 samples with a=200, b=50, `in_valid` held high → `sad_valid` rises 2 edges after the 16th accept; `sad`=2400 (0x960); `in_ready` low during DRAIN and DONE.
- Ordering: a=10, b=250 for 16 samples → `sad`=3840. Mixed block of 8×(a=5,b=3) and 8×(a=3,b=5) → `sad`=32.
- Gaps: 16 samples of a=255, b=0 with `in_valid` toggling 1,0,1,0… → exactly 16 accepted; `sad`=4080 (max, no overflow); DONE reached after 31 ACCUM cycles.
- Protocol: `start` pulsed mid-ACCUM, and `in_valid` with data held high in IDLE, DRAIN and DONE → no restart, no extra samples; `sad`=16×|a−b| for the accepted samples only.
- Reset mid-block: after 7 samples, drive `rst` low for 1 cycle → outputs 0 immediately; state IDLE. A following full block of a=1, b=0 gives `sad`=16.
- Back-to-back: `start` in the first DONE cycle → `sad_valid` drops next edge; second block of a=100, b=99 gives `sad`=16, independent of the first block's result.
